// File: rtl/riscv_pkg.sv
// Shared datapath constants and helpers used by the stream demux and its channel buffers.
package riscv_pkg;

    localparam int unsigned DEMUX_WAYS  = 4;
    localparam int unsigned DEMUX_SEL_W = 2;
    localparam int unsigned DEMUX_DEPTH = 2;

    typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;

    // Same encoding as the 4:1 datapath mux: sel k selects way k.
    function automatic logic [DEMUX_WAYS-1:0] sel_onehot(input demux_sel_t sel);
        logic [DEMUX_WAYS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// Two-entry register FIFO for one demux output channel; head word is always a registered value.
module demux_chan_buf
    import riscv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [N-1:0] din,
    input  logic         pop,
    output logic [N-1:0] dout,
    output logic         valid,
    output logic         full
);

    logic [N-1:0] mem_q [DEMUX_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         do_push;
    logic         do_pop;

    assign valid = (cnt_q != 2'd0);
    assign full  = (cnt_q == 2'(DEMUX_DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // A full buffer refuses pushes even when popped in the same cycle (no pass-through).
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & valid;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEMUX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
            end
            if (clr) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (do_pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stream_demux4.sv
// Steers one producer stream to one of four independently buffered consumer channels.
module stream_demux4
    import riscv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    input  demux_sel_t            in_sel,
    output logic [DEMUX_WAYS-1:0] out_valid,
    input  logic [DEMUX_WAYS-1:0] out_ready,
    output logic [N-1:0]          out_data0,
    output logic [N-1:0]          out_data1,
    output logic [N-1:0]          out_data2,
    output logic [N-1:0]          out_data3,
    output logic                  busy
);

    logic [N-1:0]          head [DEMUX_WAYS];
    logic [DEMUX_WAYS-1:0] full;
    logic [DEMUX_WAYS-1:0] push_vec;

    // Ready depends only on select and registered fill state, never on in_valid/out_ready.
    assign in_ready = ~flush & ~full[in_sel];
    assign push_vec = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;

    for (genvar k = 0; k < DEMUX_WAYS; k++) begin : g_chan
        demux_chan_buf #(
            .N (N)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (flush),
            .push  (push_vec[k]),
            .din   (in_data),
            .pop   (out_ready[k]),
            .dout  (head[k]),
            .valid (out_valid[k]),
            .full  (full[k])
        );
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];
    assign busy      = |out_valid;

endmodule

// File: tb/tb_stream_demux4.sv
// Directed, table-driven bench for stream_demux4 with hand-written corner-case sequences.
module tb_stream_demux4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
    logic        busy;

    int total = 0;
    int bad   = 0;

    stream_demux4 #(
        .N (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer must hold data/sel while stalled (withdrawing in_valid is tolerated).
    logic        stall_q = 1'b0;
    logic [31:0] data_q  = '0;
    logic [1:0]  sel_q   = '0;
    always @(posedge clk) begin
        if (rst_n && stall_q && in_valid) begin
            assert (in_data == data_q && in_sel == sel_q)
            else $error("producer changed in_data/in_sel while stalled");
        end
        stall_q <= rst_n && in_valid && !in_ready;
        data_q  <= in_data;
        sel_q   <= in_sel;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  ordy;
        logic [3:0]  ev;
        logic        er;
        int          ch;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [31:0] head_of(input int ch);
        case (ch)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [3:0] r, input logic f);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    int pushed;
    int rcvd;
    int mcnt;
    int cyc;

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 32'hA000_0000, 4'b0000, 4'b0000, 1'b1,  0, 32'h0};
        tbl[1]  = '{1'b1, 2'd1, 32'hA000_0001, 4'b0000, 4'b0001, 1'b1,  0, 32'hA000_0000};
        tbl[2]  = '{1'b1, 2'd2, 32'hA000_0002, 4'b0000, 4'b0011, 1'b1,  1, 32'hA000_0001};
        tbl[3]  = '{1'b1, 2'd3, 32'hA000_0003, 4'b0000, 4'b0111, 1'b1,  2, 32'hA000_0002};
        tbl[4]  = '{1'b0, 2'd0, 32'h0,         4'b1111, 4'b1111, 1'b1,  3, 32'hA000_0003};
        tbl[5]  = '{1'b1, 2'd1, 32'h11,        4'b0000, 4'b0000, 1'b1, -1, 32'h0};
        tbl[6]  = '{1'b1, 2'd1, 32'h22,        4'b0000, 4'b0010, 1'b1,  1, 32'h11};
        tbl[7]  = '{1'b1, 2'd1, 32'h33,        4'b0000, 4'b0010, 1'b0,  1, 32'h11};
        tbl[8]  = '{1'b0, 2'd3, 32'h0,         4'b0000, 4'b0010, 1'b1,  1, 32'h11};
        tbl[9]  = '{1'b1, 2'd3, 32'h44,        4'b0000, 4'b0010, 1'b1,  1, 32'h11};
        tbl[10] = '{1'b1, 2'd1, 32'h33,        4'b0010, 4'b1010, 1'b0,  3, 32'h44};
        tbl[11] = '{1'b1, 2'd1, 32'h33,        4'b0000, 4'b1010, 1'b1,  1, 32'h22};
        tbl[12] = '{1'b0, 2'd1, 32'h0,         4'b0010, 4'b1010, 1'b0,  3, 32'h44};
        tbl[13] = '{1'b0, 2'd1, 32'h0,         4'b1010, 4'b1010, 1'b1,  1, 32'h33};
        tbl[14] = '{1'b0, 2'd0, 32'h0,         4'b0000, 4'b0000, 1'b1, -1, 32'h0};

        // Reset with a push pending on channel 2.
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", {28'h0, out_valid}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset out_data%0d", k), head_of(k), 32'h0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("post-reset in_ready", {31'h0, in_ready}, 32'h1);
        adv();

        // Routing and backpressure vectors.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy, 1'b0);
            chk($sformatf("vec%0d out_valid", i), {28'h0, out_valid}, {28'h0, tbl[i].ev});
            chk($sformatf("vec%0d in_ready", i), {31'h0, in_ready}, {31'h0, tbl[i].er});
            chk($sformatf("vec%0d busy", i), {31'h0, busy}, {31'h0, |tbl[i].ev});
            if (tbl[i].ch >= 0) begin
                chk($sformatf("vec%0d out_data%0d", i, tbl[i].ch), head_of(tbl[i].ch), tbl[i].ed);
            end
            adv();
        end

        // Full-rate streaming on channel 0.
        pushed = 0;
        rcvd   = 0;
        mcnt   = 0;
        cyc    = 0;
        while (rcvd < 100 && cyc < 400) begin
            drive(pushed < 100, 2'd0, 32'h5000_0000 + 32'(pushed), 4'b0001, 1'b0);
            chk("stream out_valid", {31'h0, out_valid[0]}, {31'h0, mcnt != 0});
            if (pushed < 100) begin
                chk("stream in_ready", {31'h0, in_ready}, 32'h1);
            end
            if (mcnt != 0) begin
                chk("stream data", out_data0, 32'h5000_0000 + 32'(rcvd));
                rcvd++;
                mcnt--;
            end
            if (pushed < 100) begin
                pushed++;
                mcnt++;
            end
            adv();
            cyc++;
        end
        chk("stream words", 32'(rcvd), 32'd100);
        chk("stream cycles", 32'(cyc), 32'd101);

        // Flush with channel 2 full and channel 0 holding one word; concurrent push refused.
        drive(1'b1, 2'd2, 32'hC1, 4'b0000, 1'b0); adv();
        drive(1'b1, 2'd2, 32'hC2, 4'b0000, 1'b0); adv();
        drive(1'b1, 2'd0, 32'hB1, 4'b0000, 1'b0); adv();
        drive(1'b1, 2'd0, 32'h55, 4'b0000, 1'b1);
        chk("flush in_ready", {31'h0, in_ready}, 32'h0);
        chk("flush pre out_valid", {28'h0, out_valid}, 32'h5);
        adv();
        drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);
        chk("flush post out_valid", {28'h0, out_valid}, 32'h0);
        chk("flush post busy", {31'h0, busy}, 32'h0);
        chk("flush post in_ready", {31'h0, in_ready}, 32'h1);
        adv();

        // Asynchronous reset between edges while channel 3 is full.
        drive(1'b1, 2'd3, 32'hD1, 4'b0000, 1'b0); adv();
        drive(1'b1, 2'd3, 32'hD2, 4'b0000, 1'b0); adv();
        drive(1'b0, 2'd3, 32'h0, 4'b0000, 1'b0);
        chk("ch3 full out_valid", {28'h0, out_valid}, 32'h8);
        chk("ch3 full in_ready", {31'h0, in_ready}, 32'h0);
        chk("ch3 head", out_data3, 32'hD1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {28'h0, out_valid}, 32'h0);
        chk("async rst busy", {31'h0, busy}, 32'h0);
        chk("async rst out_data3", out_data3, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        drive(1'b0, 2'd3, 32'h0, 4'b0000, 1'b0);
        chk("after async rst in_ready", {31'h0, in_ready}, 32'h1);
        chk("after async rst out_valid", {28'h0, out_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
